// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  // Read-port behaviour: registered (standard) or first-word-fall-through.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Status flags, all registered from the next-state occupancy.
  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

  // Flag values for an empty FIFO (reset and flush).
  localparam fifo_flags_t FIFO_FLAGS_RST = '{
    full:         1'b0,
    almost_full:  1'b0,
    empty:        1'b1,
    almost_empty: 1'b1
  };

  // Address width that never collapses to zero bits.
  function automatic int clog2_min1(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // True when the parameter set describes a buildable FIFO.
  function automatic bit fifo_params_legal(input int width, input int depth,
                                           input int af_thresh, input int ae_thresh);
    bit ok;
    ok = 1'b1;
    if (width < 1 || width > 64)                 ok = 1'b0;
    if (depth < 4)                               ok = 1'b0;
    if ((depth & (depth - 1)) != 0)              ok = 1'b0;
    if (af_thresh < 1 || af_thresh > depth)      ok = 1'b0;
    if (ae_thresh < 0 || ae_thresh > depth - 1)  ok = 1'b0;
    if (ae_thresh >= af_thresh)                  ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle of the synchronous FIFO; clk and rst_n stay plain ports.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
);
  localparam int LVL_W = clog2_min1(DEPTH) + 1;

  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             almost_empty;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             underflow;

  // User side: issues requests and observes status.
  modport master (
    output clr, wr_en, din, rd_en,
    input  full, almost_full, dout, empty, almost_empty, level, overflow, underflow
  );

  // FIFO side: accepts requests and reports status.
  modport slave (
    input  clr, wr_en, din, rd_en,
    output full, almost_full, dout, empty, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// DEPTH x WIDTH storage: one synchronous write port, one read port that is
// either registered (standard mode, block RAM style) or combinational (FWFT,
// distributed RAM style).
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 16,
  parameter bit REG_READ = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_i,
  input  logic                        we_i,
  input  logic [clog2_min1(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        re_i,
  input  logic [clog2_min1(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]            rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  // NOTE: the storage array has no reset so it can map onto RAM primitives;
  // the flags guarantee no word is read before it has been written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read data: loads on an accepted read, zeroed by reset and flush.
  // NOTE: state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = REG_READ ? rdata_q : mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with selectable standard/FWFT read mode,
// programmable almost thresholds, occupancy count and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int         ADDR_W = clog2_min1(DEPTH);
  localparam int         LVL_W  = ADDR_W + 1;
  localparam fifo_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  AF_LVL    = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0]  AE_LVL    = LVL_W'(AE_THRESH);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  if (!fifo_params_legal(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_illegal_params
    $error("sync_fifo_param: illegal parameters WIDTH=%0d DEPTH=%0d AF_THRESH=%0d AE_THRESH=%0d",
           WIDTH, DEPTH, AF_THRESH, AE_THRESH);
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q,  level_d;
  fifo_flags_t       flags_q,  flags_d;
  logic              ovf_q,    ovf_d;
  logic              unf_q,    unf_d;

  logic              wr_acc, rd_acc;
  logic              wr_rej, rd_rej;
  logic [WIDTH-1:0]  mem_rdata;

  // Request qualification; a flush suppresses both requests and both errors.
  always_comb begin
    wr_acc = bus.wr_en && !flags_q.full  && !bus.clr;
    rd_acc = bus.rd_en && !flags_q.empty && !bus.clr;
    wr_rej = bus.wr_en &&  flags_q.full  && !bus.clr;
    rd_rej = bus.rd_en &&  flags_q.empty && !bus.clr;
  end

  // Next-state for pointers, occupancy, sticky errors and registered flags.
  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      level_d = level_q + (wr_acc ? LVL_ONE : '0) - (rd_acc ? LVL_ONE : '0);
      ovf_d   = ovf_q | wr_rej;
      unf_d   = unf_q | rd_rej;
    end

    // Flags come from the next occupancy so they change on the same edge as level.
    flags_d.full         = (level_d == DEPTH_LVL);
    flags_d.almost_full  = (level_d >= AF_LVL);
    flags_d.empty        = (level_d == '0);
    flags_d.almost_empty = (level_d <= AE_LVL);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      flags_q  <= FIFO_FLAGS_RST;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      flags_q  <= flags_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem_dp #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .REG_READ (MODE == FIFO_STD)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (bus.clr),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.din),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign bus.dout         = mem_rdata;
  assign bus.level        = level_q;
  assign bus.full         = flags_q.full;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  // Structural invariants of the occupancy counter and its flags.
  a_level_bound : assert property (@(posedge clk) disable iff (!rst_n) level_q <= DEPTH_LVL);
  a_full_empty  : assert property (@(posedge clk) disable iff (!rst_n) !(flags_q.full && flags_q.empty));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: four FIFO instances (24x16 std/FWFT, 8x4 std/FWFT)
// compared every cycle against a queue model, plus directed literal checks.
module tb_sync_fifo_param;

  localparam int N = 4;
  localparam int          M_DEPTH [N] = '{16, 16, 4, 4};
  localparam int          M_AF    [N] = '{14, 14, 2, 2};
  localparam int          M_AE    [N] = '{2, 2, 1, 1};
  localparam bit          M_FWFT  [N] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [63:0] M_MASK  [N] = '{64'hFF_FFFF, 64'hFF_FFFF, 64'hFF, 64'hFF};

  typedef struct packed {
    logic [63:0] level;
    logic [63:0] dout;
    logic        full;
    logic        almost_full;
    logic        empty;
    logic        almost_empty;
    logic        overflow;
    logic        underflow;
  } obs_t;

  logic clk;
  logic rst_n;

  logic        a_clr, a_wr, a_rd;
  logic [23:0] a_din;
  logic        c_clr, c_wr, c_rd;
  logic [7:0]  c_din;

  int n_checks;
  int n_errors;

  // Model state per instance.
  logic [63:0] mq     [N][$];
  bit          m_ovf  [N];
  bit          m_unf  [N];
  logic [63:0] m_dstd [N];

  obs_t obs [N];

  sync_fifo_param_if #(.WIDTH(24), .DEPTH(16)) if_a ();
  sync_fifo_param_if #(.WIDTH(24), .DEPTH(16)) if_b ();
  sync_fifo_param_if #(.WIDTH(8),  .DEPTH(4))  if_c ();
  sync_fifo_param_if #(.WIDTH(8),  .DEPTH(4))  if_d ();

  assign if_a.clr = a_clr; assign if_a.wr_en = a_wr; assign if_a.rd_en = a_rd; assign if_a.din = a_din;
  assign if_b.clr = a_clr; assign if_b.wr_en = a_wr; assign if_b.rd_en = a_rd; assign if_b.din = a_din;
  assign if_c.clr = c_clr; assign if_c.wr_en = c_wr; assign if_c.rd_en = c_rd; assign if_c.din = c_din;
  assign if_d.clr = c_clr; assign if_d.wr_en = c_wr; assign if_d.rd_en = c_rd; assign if_d.din = c_din;

  sync_fifo_param #(.WIDTH(24), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  sync_fifo_param #(.WIDTH(24), .DEPTH(16), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(2), .AE_THRESH(1))
    u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(2), .AE_THRESH(1))
    u_dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  assign obs[0] = '{level: 64'(if_a.level), dout: 64'(if_a.dout), full: if_a.full,
                    almost_full: if_a.almost_full, empty: if_a.empty, almost_empty: if_a.almost_empty,
                    overflow: if_a.overflow, underflow: if_a.underflow};
  assign obs[1] = '{level: 64'(if_b.level), dout: 64'(if_b.dout), full: if_b.full,
                    almost_full: if_b.almost_full, empty: if_b.empty, almost_empty: if_b.almost_empty,
                    overflow: if_b.overflow, underflow: if_b.underflow};
  assign obs[2] = '{level: 64'(if_c.level), dout: 64'(if_c.dout), full: if_c.full,
                    almost_full: if_c.almost_full, empty: if_c.empty, almost_empty: if_c.almost_empty,
                    overflow: if_c.overflow, underflow: if_c.underflow};
  assign obs[3] = '{level: 64'(if_d.level), dout: 64'(if_d.dout), full: if_d.full,
                    almost_full: if_d.almost_full, empty: if_d.empty, almost_empty: if_d.almost_empty,
                    overflow: if_d.overflow, underflow: if_d.underflow};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the requests seen at the last rising edge to the queue model.
  task automatic model_step(input int id);
    logic w, r, c;
    logic [63:0] d;
    int sz;
    if (id < 2) begin w = a_wr; r = a_rd; c = a_clr; d = 64'(a_din); end
    else        begin w = c_wr; r = c_rd; c = c_clr; d = 64'(c_din); end
    if (!rst_n || c) begin
      mq[id].delete();
      m_ovf[id]  = 1'b0;
      m_unf[id]  = 1'b0;
      m_dstd[id] = '0;
    end else begin
      sz = mq[id].size();
      if (w && sz == M_DEPTH[id]) m_ovf[id] = 1'b1;
      if (r && sz == 0)           m_unf[id] = 1'b1;
      if (r && sz != 0)           m_dstd[id] = mq[id].pop_front();
      if (w && sz != M_DEPTH[id]) mq[id].push_back(d & M_MASK[id]);
    end
  endtask

  task automatic compare(input int id);
    int sz;
    string p;
    sz = mq[id].size();
    p  = $sformatf("dut%0d", id);
    check({p, "_level"},        obs[id].level,                 64'(sz));
    check({p, "_full"},         64'(obs[id].full),             64'(sz == M_DEPTH[id]));
    check({p, "_empty"},        64'(obs[id].empty),            64'(sz == 0));
    check({p, "_almost_full"},  64'(obs[id].almost_full),      64'(sz >= M_AF[id]));
    check({p, "_almost_empty"}, 64'(obs[id].almost_empty),     64'(sz <= M_AE[id]));
    check({p, "_overflow"},     64'(obs[id].overflow),         64'(m_ovf[id]));
    check({p, "_underflow"},    64'(obs[id].underflow),        64'(m_unf[id]));
    if (M_FWFT[id]) begin
      if (sz != 0) check({p, "_dout_head"}, obs[id].dout, mq[id][0]);
    end else begin
      check({p, "_dout"}, obs[id].dout, m_dstd[id]);
    end
  endtask

  // Compare process: outputs are stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int id = 0; id < N; id++) begin
        model_step(id);
        compare(id);
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic step_a(input logic w, input logic [23:0] d, input logic r, input logic c);
    a_wr = w; a_din = d; a_rd = r; a_clr = c;
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    a_clr = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
    c_clr = 1'b0; c_wr = 1'b0; c_rd = 1'b0; c_din = '0;
    repeat (3) next_cycle();
    check("rst_a_level", 64'(if_a.level), 64'd0);
    check("rst_a_empty", 64'(if_a.empty), 64'd1);
    check("rst_a_dout",  64'(if_a.dout),  64'd0);
    rst_n = 1'b1;

    // Latency of a single word.
    step_a(1'b1, 24'hA5A5A5, 1'b0, 1'b0);
    check("lat_fwft_dout",  64'(if_b.dout),  64'hA5A5A5);
    check("lat_fwft_empty", 64'(if_b.empty), 64'd0);
    check("lat_std_level",  64'(if_a.level), 64'd1);
    step_a(1'b0, 24'h0, 1'b1, 1'b0);
    check("lat_std_dout",   64'(if_a.dout),  64'hA5A5A5);
    check("lat_std_empty",  64'(if_a.empty), 64'd1);

    // Fill with 1..16, probing the threshold crossings.
    for (int i = 1; i <= 16; i++) begin
      step_a(1'b1, 24'(i), 1'b0, 1'b0);
      if (i == 2)  check("ae_at_2",  64'(if_a.almost_empty), 64'd1);
      if (i == 3)  check("ae_at_3",  64'(if_a.almost_empty), 64'd0);
      if (i == 13) check("af_at_13", 64'(if_a.almost_full),  64'd0);
      if (i == 14) check("af_at_14", 64'(if_b.almost_full),  64'd1);
    end
    check("fill_full",  64'(if_a.full),  64'd1);
    check("fill_level", 64'(if_b.level), 64'd16);

    // Read and write together while full.
    step_a(1'b1, 24'h77, 1'b1, 1'b0);
    check("bfull_level",    64'(if_a.level),    64'd15);
    check("bfull_overflow", 64'(if_a.overflow), 64'd1);
    check("bfull_std_dout", 64'(if_a.dout),     64'd1);
    check("bfull_fwft_dout",64'(if_b.dout),     64'd2);

    // Drain the rest in order.
    for (int i = 2; i <= 16; i++) begin
      step_a(1'b0, 24'h0, 1'b1, 1'b0);
      check($sformatf("drain_%0d", i), 64'(if_a.dout), 64'(i));
    end
    check("drain_empty", 64'(if_a.empty), 64'd1);

    // Read and write together while empty.
    step_a(1'b1, 24'h55, 1'b1, 1'b0);
    check("bempty_level",     64'(if_a.level),     64'd1);
    check("bempty_underflow", 64'(if_b.underflow), 64'd1);
    check("bempty_std_hold",  64'(if_a.dout),      64'h10);
    check("bempty_fwft_dout", 64'(if_b.dout),      64'h55);

    // Reach level 7 with overflow still set, then flush alongside a write.
    for (int i = 0; i < 6; i++) step_a(1'b1, 24'(8'h60 + i), 1'b0, 1'b0);
    check("pre_clr_level", 64'(if_a.level),    64'd7);
    check("pre_clr_ovf",   64'(if_a.overflow), 64'd1);
    step_a(1'b1, 24'h99, 1'b0, 1'b1);
    check("clr_level", 64'(if_a.level),     64'd0);
    check("clr_empty", 64'(if_b.empty),     64'd1);
    check("clr_ovf",   64'(if_a.overflow),  64'd0);
    check("clr_unf",   64'(if_a.underflow), 64'd0);
    check("clr_dout",  64'(if_a.dout),      64'd0);

    // Burst, then asynchronous reset between clock edges.
    for (int i = 0; i < 5; i++) step_a(1'b1, 24'(8'hB0 + i), 1'b0, 1'b0);
    a_wr = 1'b1; a_din = 24'hB5; a_rd = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level",  64'(if_a.level),        64'd0);
    check("arst_empty",  64'(if_b.empty),        64'd1);
    check("arst_ae",     64'(if_a.almost_empty), 64'd1);
    check("arst_full",   64'(if_b.full),         64'd0);
    check("arst_af",     64'(if_a.almost_full),  64'd0);
    check("arst_dout",   64'(if_a.dout),         64'd0);
    a_wr = 1'b0; a_rd = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    step_a(1'b1, 24'h3C, 1'b0, 1'b0);
    check("post_rst_level", 64'(if_a.level), 64'd1);
    check("post_rst_fwft",  64'(if_b.dout),  64'h3C);
    step_a(1'b0, 24'h0, 1'b1, 1'b0);
    check("post_rst_std",   64'(if_a.dout),  64'h3C);

    // Random traffic on the 8x4 pair, alternating write- and read-heavy phases.
    for (int i = 0; i < 1000; i++) begin
      int pw;
      pw = ((i / 100) % 2 == 0) ? 75 : 25;
      c_wr  = ($urandom_range(99) < pw);
      c_rd  = ($urandom_range(99) < (100 - pw));
      c_din = 8'($urandom_range(255));
      c_clr = ($urandom_range(199) == 0);
      next_cycle();
    end
    c_wr = 1'b0; c_rd = 1'b0; c_clr = 1'b0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO for the ROIC/MIPI data path. It is used where producer and consumer already share a clock, e.g. after the CDC FIFO on the 100 MHz EIM side for line buffering and rate smoothing. It generalises the 24-bit FIFO in four ways: width, depth, selectable standard/first-word-fall-through read mode, and programmable almost-full/almost-empty thresholds. It also adds an occupancy count and sticky overflow/underflow error flags.

## Interface
- WIDTH, 24: data width in bits, 1 to 64.
- DEPTH, 16: capacity in words; power of two, at least 4.
- FWFT, 0: read mode. 0 = standard (registered read); 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2: almost_full asserts when level >= AF_THRESH. Legal range 1 to DEPTH.
- AE_THRESH, 1: almost_empty asserts when level <= AE_THRESH. Legal range 0 to DEPTH-1, and AE_THRESH < AF_THRESH.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AF_THRESH.
- rd_en  in  1  read request (FWFT: pop/acknowledge).
- dout  out  WIDTH  read data.
- empty  out  1  level == 0.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  $clog2(DEPTH)+1  words currently stored.
- overflow  out  1  sticky; set by a write while full.
- underflow  out  1  sticky; set by a read while empty.

## Operation
- Write is accepted when wr_en && !full. Read is accepted when rd_en && !empty.
- Write pointer and read pointer are binary, $clog2(DEPTH) bits wide, and wrap naturally from DEPTH-1 to 0.
- level_next = level + wr_acc - rd_acc, computed at ADDR_W+1 bits.
- Simultaneous accepted read and write: level is unchanged and both pointers advance.
- Write while full is rejected, even with a simultaneous read: memory and write pointer are unchanged, overflow is set, and the read proceeds.
- Read while empty is rejected, even with a simultaneous write: underflow is set, dout holds, and the write proceeds.
- Standard mode (FWFT=0): dout is registered. It loads mem[rd_ptr] on an accepted read and holds otherwise.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] via asynchronous memory read, and is valid whenever !empty. An accepted rd_en pops the head word. dout is undefined-but-stable while empty; it shows the last addressed word.
- full, empty, almost_full and almost_empty are registered from level_next. They are never decoded from glitching pointer logic.
- clr has priority over wr_en and rd_en in its cycle. Neither request is accepted and no error flag is set. clr zeroes the pointers, level, overflow, underflow and the standard-mode dout. Flags return to their reset values. Memory contents are not cleared.
- overflow and underflow clear only on rst_n or clr.
- Illegal parameters (non-power-of-two DEPTH, threshold ordering) stop elaboration via $error.

## Timing
- Reset values while rst_n = 0: level 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, dout 0. Takes effect immediately (asynchronous); release is synchronous to clk.
- Asserting rst_n mid-burst discards all contents. The first edge after release accepts writes.
- Write accepted at edge N: level, empty, almost flags and full update at edge N.
  - FWFT: dout is valid after edge N (0-cycle fall-through).
  - Standard: the word is readable by rd_en from cycle N+1. dout updates at the edge that accepts the read, giving 1-cycle read latency.
- Write-to-read path through memory is 1 clock minimum in both modes.
- Sustained throughput is 1 write and 1 read per clock, including at full and empty boundaries with a simultaneous request pair.

## Structure
- Package fifo_pkg holds:
  - typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  - function clog2_min1 (returns 1 for depth 1, for width safety);
  - the parameter-legality check function.
- One sub-module, fifo_mem_dp: DEPTH x WIDTH storage with one synchronous write port and one read port. The read port is combinational for FWFT and registered for standard, inferring distributed or block RAM accordingly.
- The top level holds the pointers, level counter, flag registers and error flags.

## Test plan
- Fill/drain, DEPTH=16, both modes: write 0x000001..0x000010 → full=1 and level=16 after the 16th edge; drain returns the same order; empty=1 after the 16th read.
- Boundary pair: at full, drive wr_en and rd_en together → read accepted, write rejected, overflow=1, level=15. At empty, drive both → write accepted, underflow=1, level=1.
- Thresholds, AF_THRESH=14 and AE_THRESH=2: almost_full rises on the edge where level goes 13→14; almost_empty falls on the edge where level goes 2→3.
- Latency: single write of 0xA5A5A5 into an empty FIFO.
  - FWFT: dout = 0xA5A5A5 and empty=0 after that same edge.
  - Standard: dout = 0xA5A5A5 after the rd_en edge one cycle later.
- clr and reset mid-operation: with level=7 and overflow=1, pulse clr together with wr_en → level=0, empty=1, overflow=0, no write accepted. Then drop rst_n asynchronously mid-burst → all outputs reach reset values without a clock edge.
- Wrap-around with WIDTH=8, DEPTH=4: 1000 random cycles against a queue model → zero data mismatches; level always equals model occupancy.
